// File: rtl/bus_arbiter_pkg.sv
// Shared constants, types and round-robin helpers for the four-master bus arbiter.
// Imported by the interface, the output mux and the arbiter core.
package bus_arbiter_pkg;

  localparam int N_MASTERS  = 4;
  localparam int OWNER_W    = 2;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  localparam logic RW_READ   = 1'b1;
  localparam logic RW_WRITE  = 1'b0;
  localparam logic GRANT_ON  = 1'b1;
  localparam logic GRANT_OFF = 1'b0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic               found;
    logic [OWNER_W-1:0] idx;
  } rr_pick_t;

  function automatic logic [N_MASTERS-1:0] owner_onehot(input logic [OWNER_W-1:0] idx);
    logic [N_MASTERS-1:0] g;
    g      = {N_MASTERS{GRANT_OFF}};
    g[idx] = GRANT_ON;
    return g;
  endfunction

  // Search starts at last+1 and wraps; last itself is visited last, so it only
  // wins when it is the sole candidate.
  function automatic rr_pick_t rr_pick(input logic [N_MASTERS-1:0] req,
                                       input logic [OWNER_W-1:0]   last);
    rr_pick_t             res;
    logic [OWNER_W-1:0]   idx;
    res = '0;
    for (int i = 1; i <= N_MASTERS; i++) begin
      idx = last + OWNER_W'(i);
      if (req[idx] && !res.found) begin
        res.found = 1'b1;
        res.idx   = idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Bundle of per-master request buses, grant/status outputs and the shared slave bus.
// Handshake: a master holds m_req high for its whole transfer; it owns the bus in
// every cycle its m_grant bit is high and releases by dropping m_req.
interface bus_arbiter_if
  import bus_arbiter_pkg::*;
  ();

  logic [N_MASTERS-1:0]            m_req;
  logic [N_MASTERS*ADDR_WIDTH-1:0] m_addr;
  logic [N_MASTERS-1:0]            m_as;
  logic [N_MASTERS-1:0]            m_rw;
  logic [N_MASTERS*DATA_WIDTH-1:0] m_wr_data;

  logic [N_MASTERS-1:0]            m_grant;
  logic [OWNER_W-1:0]              owner;
  logic                            bus_busy;

  logic [ADDR_WIDTH-1:0]           s_addr;
  logic                            s_as;
  logic                            s_rw;
  logic [DATA_WIDTH-1:0]           s_wr_data;

  modport master (
    output m_req, m_addr, m_as, m_rw, m_wr_data,
    input  m_grant, owner, bus_busy, s_addr, s_as, s_rw, s_wr_data
  );

  modport slave (
    input  m_req, m_addr, m_as, m_rw, m_wr_data,
    output m_grant, owner, bus_busy, s_addr, s_as, s_rw, s_wr_data
  );

endinterface

// File: rtl/bus_master_mux.sv
// Combinational steering of the granted master's bus onto the shared slave bus.
// With no grant the bus parks at address 0, no data, read direction, no strobe.
module bus_master_mux
  import bus_arbiter_pkg::*;
(
  input  logic [OWNER_W-1:0]              owner_i,
  input  logic                            bus_busy_i,
  input  logic [N_MASTERS*ADDR_WIDTH-1:0] m_addr_i,
  input  logic [N_MASTERS-1:0]            m_as_i,
  input  logic [N_MASTERS-1:0]            m_rw_i,
  input  logic [N_MASTERS*DATA_WIDTH-1:0] m_wr_data_i,
  output logic [ADDR_WIDTH-1:0]           s_addr_o,
  output logic                            s_as_o,
  output logic                            s_rw_o,
  output logic [DATA_WIDTH-1:0]           s_wr_data_o
);

  always_comb begin
    s_addr_o    = '0;
    s_wr_data_o = '0;
    s_rw_o      = RW_READ;
    s_as_o      = m_as_i[owner_i] & bus_busy_i;
    if (bus_busy_i) begin
      s_addr_o    = m_addr_i[owner_i*ADDR_WIDTH +: ADDR_WIDTH];
      s_wr_data_o = m_wr_data_i[owner_i*DATA_WIDTH +: DATA_WIDTH];
      s_rw_o      = m_rw_i[owner_i];
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Four-master round-robin bus arbiter with a hold limit after which a waiting
// master may preempt the current owner.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter  int MAX_HOLD = 16,
  localparam int HOLD_W   = $clog2(MAX_HOLD + 1)
) (
  input  logic               clk,
  input  logic               reset,
  bus_arbiter_if.slave       bus,
  output arb_state_e         state_o,
  output logic [HOLD_W-1:0]  hold_cnt_o,
  output logic [OWNER_W-1:0] last_owner_o
);

  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  arb_state_e           state_q, state_d;
  logic [N_MASTERS-1:0] grant_q, grant_d;
  logic [OWNER_W-1:0]   owner_q, owner_d;
  logic [OWNER_W-1:0]   last_q,  last_d;
  logic                 busy_q,  busy_d;
  logic [HOLD_W-1:0]    hold_q,  hold_d;

  logic [N_MASTERS-1:0] cand;
  rr_pick_t             pick;
  logic                 owner_req;

  assign owner_req = bus.m_req[owner_q];

  // While busy the current owner is excluded, so a releasing owner can never re-win.
  always_comb begin
    cand = bus.m_req;
    if (state_q == ST_BUSY) cand = bus.m_req & ~owner_onehot(owner_q);
    pick = rr_pick(cand, last_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= {N_MASTERS{GRANT_OFF}};
      owner_q <= '0;
      last_q  <= OWNER_W'(N_MASTERS - 1);
      busy_q  <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    last_d  = last_q;
    busy_d  = busy_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (pick.found) begin
          state_d = ST_BUSY;
          grant_d = owner_onehot(pick.idx);
          owner_d = pick.idx;
          last_d  = pick.idx;
          busy_d  = 1'b1;
          hold_d  = '0;
        end
      end
      ST_BUSY: begin
        if (!owner_req) begin
          hold_d = '0;
          if (pick.found) begin
            grant_d = owner_onehot(pick.idx);
            owner_d = pick.idx;
            last_d  = pick.idx;
          end else begin
            state_d = ST_IDLE;
            grant_d = {N_MASTERS{GRANT_OFF}};
            busy_d  = 1'b0;
          end
        end else if (hold_q < HOLD_MAX) begin
          hold_d = hold_q + 1'b1;
        end else if (pick.found) begin
          grant_d = owner_onehot(pick.idx);
          owner_d = pick.idx;
          last_d  = pick.idx;
          hold_d  = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = {N_MASTERS{GRANT_OFF}};
        busy_d  = 1'b0;
        hold_d  = '0;
      end
    endcase
  end

  assign bus.m_grant  = grant_q;
  assign bus.owner    = owner_q;
  assign bus.bus_busy = busy_q;

  assign state_o      = state_q;
  assign hold_cnt_o   = hold_q;
  assign last_owner_o = last_q;

  bus_master_mux u_mux (
    .owner_i     (owner_q),
    .bus_busy_i  (busy_q),
    .m_addr_i    (bus.m_addr),
    .m_as_i      (bus.m_as),
    .m_rw_i      (bus.m_rw),
    .m_wr_data_i (bus.m_wr_data),
    .s_addr_o    (bus.s_addr),
    .s_as_o      (bus.s_as),
    .s_rw_o      (bus.s_rw),
    .s_wr_data_o (bus.s_wr_data)
  );

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: reset state, handover, hold-limit preemption,
// saturation, round-robin rotation and asynchronous reset mid-transfer.
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  localparam int HOLD_W = $clog2(16 + 1);

  logic               clk;
  logic               reset;
  arb_state_e         state;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [OWNER_W-1:0] last_owner;

  int checks   = 0;
  int failures = 0;

  bus_arbiter_if bus ();

  bus_arbiter #(.MAX_HOLD(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .state_o      (state),
    .hold_cnt_o   (hold_cnt),
    .last_owner_o (last_owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [3:0] rr_exp [5];

  initial begin
    reset         = 1'b1;
    bus.m_req     = '0;
    bus.m_as      = '0;
    bus.m_rw      = 4'b0101;
    for (int i = 0; i < N_MASTERS; i++) begin
      bus.m_addr[i*32 +: 32]    = 32'hA000_0000 + 32'(i);
      bus.m_wr_data[i*32 +: 32] = 32'hD000_0000 + 32'(i);
    end
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;

    #12;
    check("rst_grant",     32'(bus.m_grant),  32'h0);
    check("rst_busy",      32'(bus.bus_busy), 32'h0);
    check("rst_owner",     32'(bus.owner),    32'h0);
    check("rst_hold",      32'(hold_cnt),     32'h0);
    check("rst_last",      32'(last_owner),   32'h3);
    check("rst_state",     32'(state),        32'(ST_IDLE));
    check("rst_s_as",      32'(bus.s_as),     32'h0);
    check("rst_s_addr",    bus.s_addr,        32'h0);
    check("rst_s_rw",      32'(bus.s_rw),     32'h1);
    check("rst_s_wdata",   bus.s_wr_data,     32'h0);

    // First arbitration: masters 1 and 3 request, master 1 wins
    reset     = 1'b0;
    bus.m_req = 4'b1010;
    bus.m_as  = 4'b0100;
    check("req_no_early_grant", 32'(bus.m_grant), 32'h0);
    step(1);
    check("g1_grant",   32'(bus.m_grant),  32'b0010);
    check("g1_owner",   32'(bus.owner),    32'h1);
    check("g1_busy",    32'(bus.bus_busy), 32'h1);
    check("g1_s_addr",  bus.s_addr,        32'hA000_0001);
    check("g1_s_rw",    32'(bus.s_rw),     32'h0);
    check("g1_s_wdata", bus.s_wr_data,     32'hD000_0001);
    check("g1_as_ungranted_blocked", 32'(bus.s_as), 32'h0);
    bus.m_as = 4'b0010;
    #1;
    check("g1_s_as", 32'(bus.s_as), 32'h1);

    // Master 1 releases with master 3 waiting: direct handover
    bus.m_req = 4'b1000;
    bus.m_as  = 4'b0000;
    step(1);
    check("ho_grant", 32'(bus.m_grant),  32'b1000);
    check("ho_owner", 32'(bus.owner),    32'h3);
    check("ho_busy",  32'(bus.bus_busy), 32'h1);
    check("ho_hold",  32'(hold_cnt),     32'h0);
    bus.m_req = 4'b0000;
    step(1);
    check("rel_grant",  32'(bus.m_grant),  32'h0);
    check("rel_busy",   32'(bus.bus_busy), 32'h0);
    check("rel_state",  32'(state),        32'(ST_IDLE));
    check("rel_s_addr", bus.s_addr,        32'h0);
    check("rel_s_rw",   32'(bus.s_rw),     32'h1);
    check("rel_last",   32'(last_owner),   32'h3);

    // Hold limit: master 0 owns, master 2 waits; preempt 17 cycles after grant
    bus.m_req = 4'b0001;
    step(1);
    check("hl_grant0", 32'(bus.m_grant), 32'b0001);
    check("hl_hold0",  32'(hold_cnt),    32'h0);
    bus.m_req = 4'b0101;
    step(16);
    check("hl_grant16", 32'(bus.m_grant), 32'b0001);
    check("hl_hold16",  32'(hold_cnt),    32'd16);
    step(1);
    check("hl_grant17", 32'(bus.m_grant), 32'b0100);
    check("hl_owner17", 32'(bus.owner),   32'h2);
    check("hl_hold17",  32'(hold_cnt),    32'h0);

    // Asynchronous reset while master 2 strobes
    bus.m_as = 4'b0100;
    #1;
    check("ar_s_as_pre", 32'(bus.s_as), 32'h1);
    #1;
    reset = 1'b1;
    #1;
    check("ar_grant", 32'(bus.m_grant),  32'h0);
    check("ar_s_as",  32'(bus.s_as),     32'h0);
    check("ar_busy",  32'(bus.bus_busy), 32'h0);
    check("ar_owner", 32'(bus.owner),    32'h0);
    check("ar_last",  32'(last_owner),   32'h3);
    bus.m_req = 4'b0000;
    bus.m_as  = 4'b0000;
    @(negedge clk);
    reset = 1'b0;
    step(1);
    check("ar_idle_after", 32'(state), 32'(ST_IDLE));

    // Sole requester saturates the hold counter and keeps the bus
    bus.m_req = 4'b0001;
    for (int i = 0; i < 40; i++) begin
      step(1);
      check("sat_grant", 32'(bus.m_grant), 32'b0001);
    end
    check("sat_hold", 32'(hold_cnt), 32'd16);
    bus.m_req = 4'b0011;
    step(1);
    check("sat_preempt", 32'(bus.m_grant), 32'b0010);
    check("sat_preempt_hold", 32'(hold_cnt), 32'h0);
    bus.m_req = 4'b0000;
    step(1);
    check("sat_idle", 32'(bus.m_grant), 32'h0);

    // Reset pulse so master 0 has priority, then rotate through all four
    reset = 1'b1;
    #1;
    reset = 1'b0;
    bus.m_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step(1);
      check("rr_grant",  32'(bus.m_grant), 32'(rr_exp[k]));
      check("rr_onehot", 32'($onehot(bus.m_grant)), 32'h1);
      bus.m_req = 4'b1111 & ~rr_exp[k];
    end
    bus.m_req = 4'b0000;
    step(2);
    check("end_idle", 32'(bus.bus_busy), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
